// File: rtl/resize_pkg.sv
// Shared types and fixed-point constants for the resize configuration path.
// Consumed by resize_cfg_ctrl and seq_udiv.
package resize_pkg;

  localparam int FRAC_BITS = 8;
  localparam int FX_W      = 24;
  localparam int WIDTH_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    WAIT_VS,
    APPLY
  } state_e;

  function automatic logic [FX_W-1:0] def_dx(
    input int unsigned in_w,
    input int unsigned out_w
  );
    return FX_W'((in_w << FRAC_BITS) / out_w);
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// start_i loads operands; done_o pulses once the 24th bit is in place.
module seq_udiv
  import resize_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [FX_W-1:0]   dividend_i,
  input  logic [WIDTH_W-1:0] divisor_i,
  output logic              done_o,
  output logic [FX_W-1:0]   quotient_o
);

  logic [FX_W-1:0]    q_q;
  logic [WIDTH_W-1:0] r_q;
  logic [WIDTH_W-1:0] d_q;
  logic [4:0]         cnt_q;
  logic               run_q;
  logic               done_q;

  logic [WIDTH_W:0] r_sh;
  logic [WIDTH_W:0] diff;
  logic             ge;

  assign r_sh = {r_q, q_q[FX_W-1]};
  assign diff = r_sh - {1'b0, d_q};
  assign ge   = r_sh >= {1'b0, d_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        q_q   <= dividend_i;
        r_q   <= '0;
        d_q   <= divisor_i;
        cnt_q <= 5'(FX_W);
        run_q <= 1'b1;
      end else if (run_q) begin
        q_q   <= {q_q[FX_W-2:0], ge};
        r_q   <= ge ? diff[WIDTH_W-1:0] : r_sh[WIDTH_W-1:0];
        cnt_q <= cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = q_q;

endmodule

// File: rtl/resize_cfg_ctrl.sv
// Horizontal-filter config sequencer: divide, then apply on VSync rise.
// Define RESIZE_CFG_ROWCHK_EN to enable the row-length checker.
module resize_cfg_ctrl
  import resize_pkg::*;
#(
  parameter int unsigned DEF_IN_WIDTH  = 640,
  parameter int unsigned DEF_OUT_WIDTH = 32,
  parameter int unsigned SWRST_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH_W-1:0] cfg_in_width,
  input  logic [WIDTH_W-1:0] cfg_out_width,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               vid_pVSync_i,
  input  logic               vid_pHSync_i,
  input  logic               vid_pVDE_i,
  output logic [FX_W-1:0]    dx,
  output logic [FX_W-1:0]    hdim,
  output logic               sw_reset,
  output logic               busy,
  output logic               cfg_err,
  output logic               row_err
);

  localparam logic [FX_W-1:0] DEF_DX =
    def_dx(DEF_IN_WIDTH, DEF_OUT_WIDTH);
  localparam logic [FX_W-1:0] DEF_HDIM =
    FX_W'(DEF_IN_WIDTH << FRAC_BITS);

  state_e          state_q;
  logic [FX_W-1:0] dx_q, hdim_q;
  logic [FX_W-1:0] dx_sh_q, hdim_sh_q;
  logic [3:0]      sw_cnt_q;
  logic            sw_q, err_q;
  logic            ready_q, busy_q;
  logic            vs_d1_q;

  logic            vs_rise, accept, bad, div_start;
  logic            div_done;
  logic [FX_W-1:0] div_q;

  assign vs_rise   = vid_pVSync_i & ~vs_d1_q;
  assign accept    = cfg_valid & ready_q;
  assign bad       = (cfg_out_width == '0) | (cfg_in_width == '0) |
                     (cfg_out_width > cfg_in_width);
  assign div_start = accept & ~bad;

  seq_udiv u_div (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .start_i    (div_start),
    .dividend_i ({cfg_in_width, 8'h00}),
    .divisor_i  (cfg_out_width),
    .done_o     (div_done),
    .quotient_o (div_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      dx_q      <= DEF_DX;
      hdim_q    <= DEF_HDIM;
      dx_sh_q   <= '0;
      hdim_sh_q <= '0;
      sw_cnt_q  <= '0;
      sw_q      <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      vs_d1_q   <= 1'b0;
    end else begin
      vs_d1_q <= vid_pVSync_i;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            err_q     <= bad;
            hdim_sh_q <= {cfg_in_width, 8'h00};
            if (!bad) begin
              state_q <= DIV;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            dx_sh_q <= div_q;
            state_q <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (vs_rise) begin
            dx_q     <= dx_sh_q;
            hdim_q   <= hdim_sh_q;
            sw_q     <= 1'b1;
            sw_cnt_q <= 4'(SWRST_CYCLES - 1);
            busy_q   <= 1'b0;
            state_q  <= APPLY;
          end
        end
        APPLY: begin
          // one idle cycle after sw_reset falls before cfg_ready returns
          if (sw_q) begin
            if (sw_cnt_q == '0) sw_q <= 1'b0;
            else sw_cnt_q <= sw_cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign dx        = dx_q;
  assign hdim      = hdim_q;
  assign sw_reset  = sw_q;
  assign busy      = busy_q;
  assign cfg_err   = err_q;
  assign cfg_ready = ready_q;

`ifdef RESIZE_CFG_ROWCHK_EN
  logic               hs_d1_q, hs_rise, rerr_q;
  logic [WIDTH_W-1:0] row_cnt_q, out_sh_q, out_app_q;

  assign hs_rise = vid_pHSync_i & ~hs_d1_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_d1_q   <= 1'b0;
      rerr_q    <= 1'b0;
      row_cnt_q <= '0;
      out_sh_q  <= '0;
      out_app_q <= WIDTH_W'(DEF_OUT_WIDTH);
    end else begin
      hs_d1_q <= vid_pHSync_i;
      if (accept) out_sh_q <= cfg_out_width;
      if (state_q == WAIT_VS && vs_rise) out_app_q <= out_sh_q;
      if (accept) rerr_q <= 1'b0;
      else if (hs_rise && row_cnt_q != '0 && row_cnt_q != out_app_q)
        rerr_q <= 1'b1;
      if (hs_rise || vs_rise || sw_q) row_cnt_q <= '0;
      else if (vid_pVDE_i) row_cnt_q <= row_cnt_q + 1'b1;
    end
  end

  assign row_err = rerr_q;
`else
  logic unused_hs_de;
  assign unused_hs_de = vid_pHSync_i ^ vid_pVDE_i;
  assign row_err      = 1'b0;
`endif

endmodule
